// File: rtl/text_pkg.sv
// Shared constants and state encoding for the score-line text buffer.
package text_pkg;

   localparam int unsigned TEXT_COLS = 16;
   localparam int unsigned TEXT_ROWS = 16;
   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned CHAR_W    = 7;
   localparam int unsigned SCORE_W   = 7;

   localparam logic [CHAR_W-1:0]  BLANK_CHAR = 7'h20;
   localparam logic [CHAR_W-1:0]  ASCII_ZERO = 7'h30;
   localparam logic [SCORE_W-1:0] SCORE_MAX  = 7'd99;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      CONV,
      WAIT_VB,
      WRITE
   } state_e;

   // Two-digit display: anything above 99 pins at 99.
   function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s);
      return (s > SCORE_MAX) ? SCORE_MAX : s;
   endfunction

endpackage

// File: rtl/text_ram.sv
// 256x7 text buffer: one write port, one registered read port (read-old-data on collision).
module text_ram
   import text_pkg::*;
(
   input  logic              pclk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [CHAR_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [CHAR_W-1:0] rdata_o
);

   logic [CHAR_W-1:0] mem [TEXT_ROWS*TEXT_COLS];
   logic [CHAR_W-1:0] rdata_q;

   always_ff @(posedge pclk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   // Output register clears on reset; the array itself is cleared by the INIT sweep.
   always_ff @(posedge pclk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= mem[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/text_buf_ctrl.sv
// Score-line text buffer controller: clears the buffer, converts two scores to
// decimal digits and writes them into the score row during vertical blanking.
module text_buf_ctrl
   import text_pkg::*;
#(
   parameter int unsigned       ROW        = 0,
   parameter int unsigned       COL_L      = 2,
   parameter int unsigned       COL_R      = 12,
   parameter logic [CHAR_W-1:0] BLANK_CHAR = text_pkg::BLANK_CHAR
) (
   input  logic               pclk,
   input  logic               rst,
   input  logic               vblnk_in,
   input  logic               score_valid,
   output logic               score_ready,
   input  logic [SCORE_W-1:0] score_l,
   input  logic [SCORE_W-1:0] score_r,
   input  logic [ADDR_W-1:0]  char_xy,
   output logic [CHAR_W-1:0]  char_code,
   output logic               busy
);

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  init_cnt_q, init_cnt_d;
   logic [SCORE_W-1:0] rem_l_q, rem_l_d, rem_r_q, rem_r_d;
   logic [3:0]         tens_l_q, tens_l_d, tens_r_q, tens_r_d;
   logic [1:0]         wr_idx_q, wr_idx_d;
   logic               ready_q, busy_q;

   logic               we_c;
   logic [ADDR_W-1:0]  waddr_c;
   logic [CHAR_W-1:0]  wdata_c;

   function automatic logic [CHAR_W-1:0] tens_char(input logic [3:0] t);
      return (t == 4'd0) ? BLANK_CHAR : ASCII_ZERO + CHAR_W'(t);
   endfunction

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q    <= INIT;
         init_cnt_q <= '0;
         rem_l_q    <= '0;
         rem_r_q    <= '0;
         tens_l_q   <= '0;
         tens_r_q   <= '0;
         wr_idx_q   <= '0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         rem_l_q    <= rem_l_d;
         rem_r_q    <= rem_r_d;
         tens_l_q   <= tens_l_d;
         tens_r_q   <= tens_r_d;
         wr_idx_q   <= wr_idx_d;
         ready_q    <= (state_d == IDLE);
         busy_q     <= (state_d != IDLE);
      end
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      rem_l_d    = rem_l_q;
      rem_r_d    = rem_r_q;
      tens_l_d   = tens_l_q;
      tens_r_d   = tens_r_q;
      wr_idx_d   = wr_idx_q;
      we_c       = 1'b0;
      waddr_c    = init_cnt_q;
      wdata_c    = BLANK_CHAR;

      unique case (state_q)
         INIT: begin
            we_c       = 1'b1;
            init_cnt_d = init_cnt_q + ADDR_W'(1);
            if (init_cnt_q == ADDR_W'(255)) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (score_valid) begin
               rem_l_d  = sat_score(score_l);
               rem_r_d  = sat_score(score_r);
               tens_l_d = '0;
               tens_r_d = '0;
               wr_idx_d = '0;
               state_d  = CONV;
            end
         end
         // Repeated subtraction, both scores in lock-step; at most 9 steps plus the exit cycle.
         CONV: begin
            if (rem_l_q >= SCORE_W'(10)) begin
               rem_l_d  = rem_l_q - SCORE_W'(10);
               tens_l_d = tens_l_q + 4'd1;
            end
            if (rem_r_q >= SCORE_W'(10)) begin
               rem_r_d  = rem_r_q - SCORE_W'(10);
               tens_r_d = tens_r_q + 4'd1;
            end
            if ((rem_l_q < SCORE_W'(10)) && (rem_r_q < SCORE_W'(10))) begin
               state_d = WAIT_VB;
            end
         end
         WAIT_VB: begin
            if (vblnk_in) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            we_c     = 1'b1;
            wr_idx_d = wr_idx_q + 2'd1;
            unique case (wr_idx_q)
               2'd0: begin
                  waddr_c = {4'(ROW), 4'(COL_L)};
                  wdata_c = tens_char(tens_l_q);
               end
               2'd1: begin
                  waddr_c = {4'(ROW), 4'(COL_L + 1)};
                  wdata_c = ASCII_ZERO + rem_l_q;
               end
               2'd2: begin
                  waddr_c = {4'(ROW), 4'(COL_R)};
                  wdata_c = tens_char(tens_r_q);
               end
               default: begin
                  waddr_c = {4'(ROW), 4'(COL_R + 1)};
                  wdata_c = ASCII_ZERO + rem_r_q;
                  state_d = IDLE;
               end
            endcase
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   text_ram u_text_ram (
      .pclk    (pclk),
      .rst     (rst),
      .we_i    (we_c & ~rst),
      .waddr_i (waddr_c),
      .wdata_i (wdata_c),
      .raddr_i (char_xy),
      .rdata_o (char_code)
   );

   assign score_ready = ready_q;
   assign busy        = busy_q;

endmodule
